// File: rtl/vga_pixel_fetch_pkg.sv
// ==== vga_pixel_fetch_pkg: shared constants/helpers for the pixel fetch path. Rev 1.0 ====
`default_nettype none

package vga_pixel_fetch_pkg;

  localparam int   H_VIS     = 1024;
  localparam logic SYNC_IDLE = 1'b1;  // syncs are active-low, idle high

  function automatic bit bpp_legal(input int bpp);
    return (bpp == 1) || (bpp == 2) || (bpp == 4) || (bpp == 8);
  endfunction

  function automatic int ppw(input int bpp);
    return 32 / bpp;
  endfunction

  function automatic int lat(input int rd_lat);
    return rd_lat + 2;
  endfunction

endpackage

`default_nettype wire

// File: rtl/vga_pixel_fetch_if.sv
// ==== vga_pixel_fetch_if: video-RAM read port and CPU base/palette writes. Rev 1.0 ====
`default_nettype none

interface vga_pixel_fetch_if #(
  parameter int ADDR_W = 16,
  parameter int RGB_W  = 12
);
  logic [ADDR_W-1:0] vram_addr;
  logic              vram_re;
  logic [31:0]       vram_rdata;
  logic              base_we;
  logic [ADDR_W-1:0] base_wdata;
  logic              pal_we;
  logic [7:0]        pal_idx;
  logic [RGB_W-1:0]  pal_wdata;

  modport master (
    output vram_addr, vram_re,
    input  vram_rdata, base_we, base_wdata, pal_we, pal_idx, pal_wdata
  );

  modport slave (
    input  vram_addr, vram_re,
    output vram_rdata, base_we, base_wdata, pal_we, pal_idx, pal_wdata
  );
endinterface

`default_nettype wire

// File: rtl/vga_sync_delay.sv
// ==== vga_sync_delay: DEPTH-stage delay of {avr, sub, hs, vs} matching the RAM path. Rev 1.0 ====
`default_nettype none

module vga_sync_delay
  import vga_pixel_fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int SUB_W = 3
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             avr_in,
  input  wire logic [SUB_W-1:0] sub_in,
  input  wire logic             hs_in,
  input  wire logic             vs_in,
  output logic                  avr_out,
  output logic [SUB_W-1:0]      sub_out,
  output logic                  hs_out,
  output logic                  vs_out
);

  logic [DEPTH-1:0] r_avr;
  logic [DEPTH-1:0] r_hs;
  logic [DEPTH-1:0] r_vs;
  logic [SUB_W-1:0] r_sub [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_avr <= '0;
      r_hs  <= {DEPTH{SYNC_IDLE}};
      r_vs  <= {DEPTH{SYNC_IDLE}};
      for (int i = 0; i < DEPTH; i++) r_sub[i] <= '0;
    end else begin
      r_avr[0] <= avr_in;
      r_hs[0]  <= hs_in;
      r_vs[0]  <= vs_in;
      r_sub[0] <= sub_in;
      for (int i = 1; i < DEPTH; i++) begin
        r_avr[i] <= r_avr[i-1];
        r_hs[i]  <= r_hs[i-1];
        r_vs[i]  <= r_vs[i-1];
        r_sub[i] <= r_sub[i-1];
      end
    end
  end

  assign avr_out = r_avr[DEPTH-1];
  assign hs_out  = r_hs[DEPTH-1];
  assign vs_out  = r_vs[DEPTH-1];
  assign sub_out = r_sub[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/vga_pixel_fetch.sv
// ==== vga_pixel_fetch: VRAM word fetch, pixel unpack, palette lookup, sync alignment. Rev 1.0 ====
`default_nettype none

module vga_pixel_fetch
  import vga_pixel_fetch_pkg::*;
#(
  parameter int BPP    = 4,
  parameter int ADDR_W = 16,
  parameter int RD_LAT = 1,
  parameter int RGB_W  = 12
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  input  wire logic         avr,
  input  wire logic         h_sync,
  input  wire logic         v_sync,
  input  wire logic [9:0]   line_num,
  input  wire logic [9:0]   pixel_num,
  vga_pixel_fetch_if.master bus,
  output logic [RGB_W-1:0]  rgb,
  output logic              hs_out,
  output logic              vs_out,
  output logic              vblank_irq
);

  localparam int C_PPW      = ppw(BPP);
  localparam int C_SUB_W    = $clog2(C_PPW);
  localparam int C_WPL_LOG2 = $clog2(H_VIS) - C_SUB_W;
  localparam int C_DEPTH    = lat(RD_LAT) - 1;

  generate
    if (!bpp_legal(BPP)) begin : g_bpp_illegal
      $error("vga_pixel_fetch: BPP must be 1, 2, 4 or 8");
    end
  endgenerate

  logic [ADDR_W-1:0] r_addr;
  logic              r_re;
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W-1:0] r_shadow;
  logic              r_vs_prev;
  logic              r_irq;
  logic [RGB_W-1:0]  r_pal [2**BPP];
  logic [RGB_W-1:0]  r_rgb;
  logic              r_hs;
  logic              r_vs;

  logic [ADDR_W-1:0] w_line_off;
  logic [ADDR_W-1:0] w_px_off;
  logic [C_SUB_W-1:0] w_sub;
  logic              w_vs_fall;
  logic              w_avr_d;
  logic [C_SUB_W-1:0] w_sub_d;
  logic              w_hs_d;
  logic              w_vs_d;
  logic [BPP-1:0]    w_idx;
  logic              w_unused_pal_idx;

  // Stage A: word address; sum wraps naturally at ADDR_W bits
  assign w_line_off = ADDR_W'(line_num) << C_WPL_LOG2;
  assign w_px_off   = ADDR_W'(pixel_num >> C_SUB_W);
  assign w_sub      = pixel_num[C_SUB_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr <= '0;
      r_re   <= 1'b0;
    end else begin
      r_re <= avr;
      if (avr) r_addr <= r_base + w_line_off + w_px_off;
    end
  end

  assign bus.vram_addr = r_addr;
  assign bus.vram_re   = r_re;

  // A base write coinciding with the swap lands in shadow only
  assign w_vs_fall = r_vs_prev & ~v_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_base    <= '0;
      r_shadow  <= '0;
      r_vs_prev <= SYNC_IDLE;
      r_irq     <= 1'b0;
    end else begin
      r_vs_prev <= v_sync;
      r_irq     <= w_vs_fall;
      if (bus.base_we) r_shadow <= bus.base_wdata;
      if (w_vs_fall)   r_base   <= r_shadow;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2**BPP; i++) r_pal[i] <= '0;
    end else if (bus.pal_we) begin
      r_pal[bus.pal_idx[BPP-1:0]] <= bus.pal_wdata;
    end
  end

  assign w_unused_pal_idx = ^bus.pal_idx;

  vga_sync_delay #(
    .DEPTH (C_DEPTH),
    .SUB_W (C_SUB_W)
  ) u_sync_delay (
    .clk     (clk),
    .rst_n   (rst_n),
    .avr_in  (avr),
    .sub_in  (w_sub),
    .hs_in   (h_sync),
    .vs_in   (v_sync),
    .avr_out (w_avr_d),
    .sub_out (w_sub_d),
    .hs_out  (w_hs_d),
    .vs_out  (w_vs_d)
  );

  // Stage C: pixel 0 of each word occupies the LSBs
  assign w_idx = bus.vram_rdata[w_sub_d*BPP +: BPP];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rgb <= '0;
      r_hs  <= SYNC_IDLE;
      r_vs  <= SYNC_IDLE;
    end else begin
      r_rgb <= w_avr_d ? r_pal[w_idx] : '0;
      r_hs  <= w_hs_d;
      r_vs  <= w_vs_d;
    end
  end

  assign rgb        = r_rgb;
  assign hs_out     = r_hs;
  assign vs_out     = r_vs;
  assign vblank_irq = r_irq;

endmodule

`default_nettype wire

// File: tb/tb_vga_pixel_fetch.sv
// ==== tb_vga_pixel_fetch: directed self-checking bench for vga_pixel_fetch. Rev 1.0 ====
`default_nettype none

module tb_vga_pixel_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        avr = 1'b0;
  logic        h_sync = 1'b1;
  logic        v_sync = 1'b1;
  logic [9:0]  line_num = '0;
  logic [9:0]  pixel_num = '0;
  logic [11:0] rgb;
  logic        hs_out;
  logic        vs_out;
  logic        vblank_irq;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [0:65535];

  vga_pixel_fetch_if #(.ADDR_W(16), .RGB_W(12)) bus ();

  vga_pixel_fetch #(
    .BPP    (4),
    .ADDR_W (16),
    .RD_LAT (1),
    .RGB_W  (12)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .avr        (avr),
    .h_sync     (h_sync),
    .v_sync     (v_sync),
    .line_num   (line_num),
    .pixel_num  (pixel_num),
    .bus        (bus),
    .rgb        (rgb),
    .hs_out     (hs_out),
    .vs_out     (vs_out),
    .vblank_irq (vblank_irq)
  );

  always #5 clk = ~clk;

  // Synchronous video RAM, one clock read latency
  always @(posedge clk) begin
    if (bus.vram_re) bus.vram_rdata <= mem[bus.vram_addr];
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pix(input logic a, input int ln, input int px);
    avr       = a;
    line_num  = 10'(ln);
    pixel_num = 10'(px);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_rgb"},  32'(rgb),           32'h0);
    chk({tag, "_hs"},   32'(hs_out),        32'h1);
    chk({tag, "_vs"},   32'(vs_out),        32'h1);
    chk({tag, "_re"},   32'(bus.vram_re),   32'h0);
    chk({tag, "_addr"}, 32'(bus.vram_addr), 32'h0);
    chk({tag, "_irq"},  32'(vblank_irq),    32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 32'h0;
    mem[0] = 32'h7654_3210;
    bus.vram_rdata = 32'h0;
    bus.base_we    = 1'b0;
    bus.base_wdata = '0;
    bus.pal_we     = 1'b0;
    bus.pal_idx    = '0;
    bus.pal_wdata  = '0;

    #1 rst_n = 1'b0;
    #2 chk_reset_state("por");
    tick();
    rst_n = 1'b1;

    // Palette i -> i*0x111
    for (int i = 0; i < 16; i++) begin
      bus.pal_we    = 1'b1;
      bus.pal_idx   = 8'(i);
      bus.pal_wdata = 12'(i * 12'h111);
      tick();
    end
    bus.pal_we = 1'b0;

    // Address of line 3 pixel 17 at 8 pixels per word
    pix(1'b1, 3, 17);
    tick();
    chk("addr_l3_p17", 32'(bus.vram_addr), 32'd386);
    chk("re_active",   32'(bus.vram_re),   32'h1);

    // Unpack word 0 through the palette; each pixel emerges 3 clocks later
    for (int c = 0; c < 11; c++) begin
      if (c < 8) pix(1'b1, 0, c);
      else       pix(1'b0, 0, 0);
      tick();
      if (c >= 2)
        chk($sformatf("rgb_px%0d", c - 2), 32'(rgb),
            (c - 2 < 8) ? 32'((c - 2) * 12'h111) : 32'h0);
    end

    // h_sync falls; hs_out follows three clocks later
    h_sync = 1'b0;
    tick();
    tick();
    chk("hs_lat2", 32'(hs_out), 32'h1);
    tick();
    chk("hs_lat3", 32'(hs_out), 32'h0);
    chk("rgb_blank_ram_data", 32'(rgb), 32'h0);
    h_sync = 1'b1;

    // Shadow write mid-frame must not move the active base
    bus.base_we    = 1'b1;
    bus.base_wdata = 16'h1000;
    tick();
    bus.base_we = 1'b0;
    pix(1'b1, 0, 0);
    tick();
    chk("addr_before_swap", 32'(bus.vram_addr), 32'h0);
    pix(1'b0, 0, 0);
    v_sync = 1'b0;
    tick();
    chk("irq_pulse", 32'(vblank_irq), 32'h1);
    tick();
    chk("irq_one_clock", 32'(vblank_irq), 32'h0);
    tick();
    chk("vs_lat3", 32'(vs_out), 32'h0);
    v_sync = 1'b1;
    pix(1'b1, 0, 0);
    tick();
    chk("addr_after_swap", 32'(bus.vram_addr), 32'h1000);

    // Base write in the swap cycle only reaches shadow
    pix(1'b0, 0, 0);
    v_sync         = 1'b0;
    bus.base_we    = 1'b1;
    bus.base_wdata = 16'hFF80;
    tick();
    bus.base_we = 1'b0;
    chk("irq_second", 32'(vblank_irq), 32'h1);
    pix(1'b1, 0, 8);
    tick();
    chk("addr_swap_cycle_write", 32'(bus.vram_addr), 32'h1001);
    pix(1'b0, 0, 0);
    v_sync = 1'b1;
    tick();
    v_sync = 1'b0;
    tick();
    chk("irq_third", 32'(vblank_irq), 32'h1);
    v_sync = 1'b1;
    pix(1'b1, 1, 0);
    tick();
    chk("addr_wrap", 32'(bus.vram_addr), 32'h0000);
    pix(1'b1, 1, 8);
    tick();
    chk("addr_wrap_p8", 32'(bus.vram_addr), 32'h0001);

    // Palette write colliding with an index-5 lookup returns the old colour
    pix(1'b1, 1, 5);
    tick();
    pix(1'b0, 0, 0);
    tick();
    bus.pal_we    = 1'b1;
    bus.pal_idx   = 8'd5;
    bus.pal_wdata = 12'hABC;
    tick();
    bus.pal_we = 1'b0;
    chk("pal_same_cycle_old", 32'(rgb), 32'h555);
    pix(1'b1, 1, 5);
    tick();
    pix(1'b0, 0, 0);
    tick();
    tick();
    chk("pal_new_colour", 32'(rgb), 32'hABC);

    // Mid-frame reset with live video and asserted syncs
    pix(1'b1, 1, 5);
    h_sync = 1'b0;
    tick();
    tick();
    tick();
    chk("pre_rst_rgb", 32'(rgb),    32'hABC);
    chk("pre_rst_hs",  32'(hs_out), 32'h0);
    v_sync = 1'b0;
    tick();
    chk("pre_rst_irq", 32'(vblank_irq), 32'h1);
    #2 rst_n = 1'b0;
    #1 chk_reset_state("mid_rst");
    tick();
    pix(1'b0, 0, 0);
    h_sync = 1'b1;
    v_sync = 1'b1;
    rst_n  = 1'b1;
    tick();
    pix(1'b1, 0, 8);
    tick();
    chk("post_rst_base", 32'(bus.vram_addr), 32'h0001);
    pix(1'b0, 0, 0);
    tick();
    tick();
    chk("post_rst_pal_cleared", 32'(rgb), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
